ws2812_decoder: RTL and testbench
=================================

WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 Parameter W, default 24; bits per LED word, MSB first (GRB order).
REQ-002 Parameter T_THRESH, default 30; high-pulse cycle count at or above which a bit decodes as 1.
REQ-003 Parameter RESET_CYCLES, default 2500; low-time cycle count that ends a frame (latch).
REQ-004 Parameter PULSE_MAX, default 60; longest legal high pulse in cycles (error feature only).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 din  input  1  asynchronous single-wire WS2812 data line.
REQ-008 data_out  output  W  last complete decoded word.
REQ-009 data_valid  output  1  one-cycle pulse: data_out updated this cycle.
REQ-010 word_idx  output  8  index in frame of the word on data_out, 0-based.
REQ-011 frame_end  output  1  one-cycle pulse: latch low period detected.
REQ-012 err  output  1  one-cycle pulse on protocol error; only with WS2812_DEC_ERR_EN defined.

Function
REQ-013 din SHALL pass through a 2-flop synchronizer; all decoding uses synchronized value din_s; din_s lags din by 2 cycles.
REQ-014 States SHALL be WAIT_LATCH, LOW, HIGH.
REQ-015 WAIT_LATCH: count consecutive low cycles; go to LOW after RESET_CYCLES lows; any high restarts count; no bits decoded.
REQ-016 LOW: din_s high -> HIGH, high counter set to 1; low count reaching RESET_CYCLES -> pulse frame_end, clear bit count and word counter, stay LOW, count saturates (one frame_end per low period).
REQ-017 HIGH: high counter increments each cycle din_s high; counter saturates at its maximum, never wraps.
REQ-018 HIGH with din_s low: decoded bit = (high count >= T_THRESH); shift into buffer LSB side, left shift; bit count +1; go LOW, low counter set to 1.
REQ-019 When bit count reaches W: data_out <= completed buffer, data_valid high next cycle, word_idx <= word counter, word counter +1, bit count cleared.
REQ-020 Latency: data_valid asserted exactly 1 cycle after the cycle din_s is first sampled low ending the W-th pulse.
REQ-021 Partial word (0 < bit count < W) at frame_end SHALL be discarded; data_out unchanged.
REQ-022 Word counter saturates at 255; word_idx stays 255 for further words.
REQ-023 frame_end and data_valid never asserted in same cycle (latch requires prior falling edge).
REQ-024 data_out and word_idx hold between data_valid pulses.

Reset
REQ-025 rst high at any clock edge, including mid-word: state WAIT_LATCH, all counters 0, buffer 0.
REQ-026 Output reset values: data_out 0, data_valid 0, word_idx 0, frame_end 0, err 0.
REQ-027 After rst, first decoded bit only after a full RESET_CYCLES low period.

Configuration
REQ-028 Macro WS2812_DEC_ERR_EN defined: err port exists; err pulses one cycle and bit count clears (word discarded) when high pulse exceeds PULSE_MAX, or when partial word discarded at frame_end (err coincident with frame_end).
REQ-029 Macro undefined: no err port, no PULSE_MAX check; long high pulses decode as 1; partial words discarded silently.

Verification
REQ-030 rst, din low 2500 cycles, 24 pulses of 40 high/22 low, then low -> data_valid 1 cycle with data_out 0xFFFFFF, word_idx 0.
REQ-031 Pattern 0xA5C3F0 (1=40/22, 0=20/42 cycles), two words, then 2500 low -> data_out 0xA5C3F0 word_idx 0, then word_idx 1, then frame_end once.
REQ-032 Boundary: high 29 cycles -> bit 0; high 30 cycles -> bit 1.
REQ-033 10 bits sent then 2500 low -> no data_valid, frame_end pulse, err pulse (macro on); next frame word_idx restarts 0.
REQ-034 rst asserted after 12 bits, released, 2500 low, 24 bits of 0 -> data_out 0x000000 with data_valid, no stale bits.
REQ-035 Macro on: high pulse 61 cycles -> err pulse 1 cycle, current word discarded; macro off: decoded as bit 1.

Source files
------------

// File: rtl/ws2812_decoder.sv
// ws2812_decoder: WS2812 single-wire bit/word decoder with frame latch detection; WS2812_DEC_ERR_EN adds the err output
module ws2812_decoder #(
    parameter int W            = 24,
    parameter int T_THRESH     = 30,
    parameter int RESET_CYCLES = 2500,
    parameter int PULSE_MAX    = 60
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    output logic [W-1:0] data_out,
    output logic         data_valid,
    output logic [7:0]   word_idx,
    output logic         frame_end
`ifdef WS2812_DEC_ERR_EN
    ,
    output logic         err
`endif
);
    localparam int HMAX = (PULSE_MAX > T_THRESH) ? PULSE_MAX : T_THRESH;
    localparam int HW   = $clog2(HMAX + 2);
    localparam int LW   = $clog2(RESET_CYCLES + 1);
    localparam int BW   = $clog2(W + 1);

    typedef enum logic [1:0] {WAIT_LATCH, LOW, HIGH} state_t;

    state_t        state;
    logic          din_m, din_s;
    logic [LW-1:0] low_cnt;
    logic [HW-1:0] high_cnt;
    logic [BW-1:0] bit_cnt;
    logic [7:0]    word_cnt;
    logic [W-1:0]  buffer;
    logic [W-1:0]  shifted;
    logic          too_long;
    logic          latch_hit;

    assign shifted   = {buffer[W-2:0], high_cnt >= HW'(T_THRESH)};
    assign latch_hit = low_cnt == LW'(RESET_CYCLES - 1);
`ifdef WS2812_DEC_ERR_EN
    assign too_long = high_cnt > HW'(PULSE_MAX);
`else
    assign too_long = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            din_m      <= 1'b0;
            din_s      <= 1'b0;
            state      <= WAIT_LATCH;
            low_cnt    <= '0;
            high_cnt   <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            buffer     <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            word_idx   <= '0;
            frame_end  <= 1'b0;
        end else begin
            din_m      <= din;
            din_s      <= din_m;
            data_valid <= 1'b0;
            frame_end  <= 1'b0;
            case (state)
                WAIT_LATCH: begin
                    low_cnt <= din_s ? '0 : low_cnt + 1'b1;
                    if (!din_s && latch_hit)
                        state <= LOW;
                end
                LOW: begin
                    if (din_s) begin
                        state    <= HIGH;
                        high_cnt <= HW'(1);
                    end else if (low_cnt != LW'(RESET_CYCLES)) begin
                        low_cnt <= low_cnt + 1'b1;
                        if (latch_hit) begin
                            frame_end <= 1'b1;
                            bit_cnt   <= '0;
                            word_cnt  <= '0;
                        end
                    end
                end
                HIGH: begin
                    if (din_s) begin
                        high_cnt <= (&high_cnt) ? high_cnt : high_cnt + 1'b1;
                    end else begin
                        state   <= LOW;
                        low_cnt <= LW'(1);
                        if (too_long) begin
                            bit_cnt <= '0;
                        end else begin
                            buffer <= shifted;
                            if (bit_cnt == BW'(W - 1)) begin
                                data_out   <= shifted;
                                data_valid <= 1'b1;
                                word_idx   <= word_cnt;
                                word_cnt   <= (&word_cnt) ? word_cnt : word_cnt + 8'd1;
                                bit_cnt    <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= WAIT_LATCH;
            endcase
        end
    end

`ifdef WS2812_DEC_ERR_EN
    // Overlong pulse at its falling edge, or a partial word thrown away at the latch.
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else
            err <= !din_s && ((state == HIGH && too_long) || (state == LOW && latch_hit && bit_cnt != '0));
    end
`endif
endmodule

// File: tb/tb_ws2812_decoder.sv
// tb_ws2812_decoder: randomized and directed checks of ws2812_decoder against a pulse-level reference model
module tb_ws2812_decoder;
    localparam int W  = 24;
    localparam int T  = 30;
    localparam int RC = 2500;
    localparam int PM = 60;
`ifdef WS2812_DEC_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         din = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic [7:0]   word_idx;
    logic         frame_end;
    logic         err;

    logic         din2 = 1'b0;
    logic [1:0]   data_out2;
    logic         dv2;
    logic [7:0]   idx2;
    logic         fe2;
    logic         err2;

    always #5 clk = ~clk;

    ws2812_decoder #(.W(W), .T_THRESH(T), .RESET_CYCLES(RC), .PULSE_MAX(PM)) dut (
        .clk(clk), .rst(rst), .din(din), .data_out(data_out), .data_valid(data_valid),
        .word_idx(word_idx), .frame_end(frame_end)
`ifdef WS2812_DEC_ERR_EN
        , .err(err)
`endif
    );

    ws2812_decoder #(.W(2), .T_THRESH(3), .RESET_CYCLES(20), .PULSE_MAX(8)) dut2 (
        .clk(clk), .rst(rst), .din(din2), .data_out(data_out2), .data_valid(dv2),
        .word_idx(idx2), .frame_end(fe2)
`ifdef WS2812_DEC_ERR_EN
        , .err(err2)
`endif
    );

`ifndef WS2812_DEC_ERR_EN
    assign err  = 1'b0;
    assign err2 = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [W+7:0] got_q[$];
    int fe_cnt = 0, err_cnt = 0, overlap = 0, dv_cyc = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid) begin
                got_q.push_back({word_idx, data_out});
                dv_cyc = cyc;
            end
            fe_cnt  += int'(frame_end);
            err_cnt += int'(err);
            overlap += int'(data_valid && frame_end);
        end
    end

    int dv2_cnt = 0, bad2 = 0;
    always @(negedge clk) begin
        if (!rst && dv2) begin
            if (idx2 != 8'((dv2_cnt > 255) ? 255 : dv2_cnt))
                bad2++;
            dv2_cnt++;
        end
    end

    logic [W+7:0] exp_q[$];
    int m_words = 0, m_bits = 0, exp_fe = 0, exp_err = 0;
    logic [W-1:0] m_buf = '0;
    int got_base = 0, fe_base = 0, err_base = 0, ov_base = 0, fall_cyc = 0;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Reference: each pulse's bit comes straight from its high length.
    task automatic model_pulse(int h);
        if (ERR_EN && h > PM) begin
            exp_err++;
            m_bits = 0;
        end else begin
            m_buf = (m_buf << 1) | W'(h >= T);
            m_bits++;
            if (m_bits == W) begin
                exp_q.push_back({8'((m_words > 255) ? 255 : m_words), m_buf});
                m_words++;
                m_bits = 0;
            end
        end
    endtask

    task automatic model_latch();
        exp_fe++;
        if (ERR_EN && m_bits != 0)
            exp_err++;
        m_bits = 0;
        m_words = 0;
    endtask

    task automatic drive(bit v, int n);
        repeat (n) @(negedge clk) din = v;
    endtask

    task automatic pulse(int h, int l);
        drive(1'b1, h);
        @(negedge clk) din = 1'b0;
        fall_cyc = cyc;
        drive(1'b0, l - 1);
        model_pulse(h);
    endtask

    task automatic send_word(logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--)
            if (v[i]) pulse(40, 22); else pulse(20, 42);
    endtask

    task automatic rand_pulse();
        if ($urandom_range(1, 0) == 1)
            pulse($urandom_range(PM + 3, T), $urandom_range(40, 1));
        else
            pulse($urandom_range(T - 1, 1), $urandom_range(40, 1));
    endtask

    task automatic begin_scen();
        exp_q.delete();
        exp_fe = 0;
        exp_err = 0;
        got_base = got_q.size();
        fe_base = fe_cnt;
        err_base = err_cnt;
        ov_base = overlap;
    endtask

    task automatic end_scen(string tag);
        drive(1'b0, RC + 10);
        model_latch();
        check({tag, ":words"}, got_q.size() - got_base, exp_q.size());
        for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++)
            check($sformatf("%s:word%0d", tag, i), got_q[got_base + i], exp_q[i]);
        check({tag, ":frame_end"}, fe_cnt - fe_base, exp_fe);
        check({tag, ":err"}, err_cnt - err_base, exp_err);
        check({tag, ":overlap"}, overlap - ov_base, 0);
        begin_scen();
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst:data_out", data_out, 0);
        check("rst:data_valid", data_valid, 0);
        check("rst:word_idx", word_idx, 0);
        check("rst:frame_end", frame_end, 0);
        check("rst:err", err, 0);
        rst = 1'b0;
        m_bits = 0;
        m_words = 0;
        m_buf = '0;
        drive(1'b0, RC + 10);
        begin_scen();
    endtask

    initial begin
        do_reset();

        for (int i = 0; i < W; i++) pulse(40, 22);
        drive(1'b0, 5);
        check("ones:latency", dv_cyc - fall_cyc, 3);
        end_scen("ones");
        check("ones:hold", data_out, 24'hFFFFFF);

        send_word(24'hA5C3F0);
        send_word(24'hA5C3F0);
        end_scen("a5c3f0");

        for (int i = 0; i < W; i++) pulse((i % 2 == 0) ? 29 : 30, 22);
        end_scen("thresh");

        for (int i = 0; i < 10; i++) pulse(40, 22);
        end_scen("partial");
        check("partial:hold", data_out, 24'h555555);
        send_word(W'($urandom));
        end_scen("after_partial");

        for (int i = 0; i < 12; i++) pulse(40, 22);
        do_reset();
        for (int i = 0; i < W; i++) pulse(20, 42);
        end_scen("post_reset");

        for (int i = 0; i < 5; i++) pulse(40, 22);
        pulse(61, 22);
        send_word(W'($urandom));
        end_scen("long_pulse");

        for (int f = 0; f < 6; f++) begin
            int n = $urandom_range(3, 1) * W + $urandom_range(3, 0);
            for (int i = 0; i < n; i++) rand_pulse();
            end_scen($sformatf("rand%0d", f));
        end

        // Short-word instance reaches the word counter saturation quickly.
        for (int k = 0; k < 260; k++) begin
            repeat (4) @(negedge clk) din2 = 1'b1;
            repeat (2) @(negedge clk) din2 = 1'b0;
            repeat (1) @(negedge clk) din2 = 1'b1;
            repeat (2) @(negedge clk) din2 = 1'b0;
        end
        repeat (4) @(negedge clk);
        check("sat:count", dv2_cnt, 260);
        check("sat:idx_seq", bad2, 0);
        check("sat:last_idx", idx2, 255);
        check("sat:data", data_out2, 2'b10);
        repeat (30) @(negedge clk) din2 = 1'b0;
        repeat (4) @(negedge clk) din2 = 1'b1;
        repeat (2) @(negedge clk) din2 = 1'b0;
        repeat (4) @(negedge clk) din2 = 1'b1;
        repeat (4) @(negedge clk) din2 = 1'b0;
        check("sat:restart_idx", idx2, 0);
        check("sat:restart_data", data_out2, 2'b11);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
